// File: rtl/ula_pkg.sv
// ula_pkg: shared types and constants for the ALU-control stage.
//   ula_code_e : 3-bit ALU operation codes driven on ula_ctrl
//   alu_op_e   : 2-bit ALUOp field from main control
//   Funct*     : R-type funct encodings recognised when ALUOp selects funct decode
package ula_pkg;

  typedef enum logic [2:0] {
    UlaAnd = 3'b000,
    UlaOr  = 3'b001,
    UlaAdd = 3'b010,
    UlaSub = 3'b110,
    UlaSlt = 3'b111
  } ula_code_e;

  typedef enum logic [1:0] {
    AluOpAdd   = 2'b00,
    AluOpSub   = 2'b01,
    AluOpFunct = 2'b10,
    AluOpOr    = 2'b11
  } alu_op_e;

  localparam logic [5:0] FunctAdd = 6'b100000;
  localparam logic [5:0] FunctSub = 6'b100010;
  localparam logic [5:0] FunctAnd = 6'b100100;
  localparam logic [5:0] FunctOr  = 6'b100101;
  localparam logic [5:0] FunctSlt = 6'b101010;

  localparam int unsigned NumCnt = 8;

endpackage

// File: rtl/ula_op_decode.sv
// ula_op_decode: purely combinational ALUOp/funct to ULAcontrol decoder.
// Ports:
//   i_alu_op  [1:0] main-control ALUOp
//   i_funct   [5:0] instruction funct field
//   o_code    [2:0] ALU operation code
//   o_illegal       funct not recognised under funct decode
module ula_op_decode
  import ula_pkg::*;
(
  input  logic [1:0] i_alu_op,
  input  logic [5:0] i_funct,
  output logic [2:0] o_code,
  output logic       o_illegal
);

  alu_op_e w_op;
  assign w_op = alu_op_e'(i_alu_op);

  always_comb begin
    o_code    = UlaAdd;
    o_illegal = 1'b0;
    unique case (w_op)
      AluOpAdd: o_code = UlaAdd;
      AluOpSub: o_code = UlaSub;
      AluOpOr:  o_code = UlaOr;
      AluOpFunct: begin
        case (i_funct)
          FunctAdd: o_code = UlaAdd;
          FunctSub: o_code = UlaSub;
          FunctAnd: o_code = UlaAnd;
          FunctOr:  o_code = UlaOr;
          FunctSlt: o_code = UlaSlt;
          // Unknown funct falls back to ADD and is flagged
          default:  o_illegal = 1'b1;
        endcase
      end
      default: o_code = UlaAdd;
    endcase
  end

endmodule

// File: rtl/ula_ctrl_stage.sv
// ula_ctrl_stage: registered ALU-control stage with per-code op counters.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   in_valid            decode slot carries an instruction
//   alu_op, funct       decode inputs
//   stall, flush        hold stage / insert bubble (flush wins)
//   clr_stats           zero all counters
//   rd_idx              op counter select for readout
//   out_valid, ula_ctrl, illegal  registered decode result
//   rd_data             counter[rd_idx] from previous edge
//   illegal_count       count of illegal loads
module ula_ctrl_stage
  import ula_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [1:0]  alu_op,
  input  logic [5:0]  funct,
  input  logic        stall,
  input  logic        flush,
  input  logic        clr_stats,
  input  logic [2:0]  rd_idx,
  output logic        out_valid,
  output logic [2:0]  ula_ctrl,
  output logic        illegal,
  output logic [31:0] rd_data,
  output logic [31:0] illegal_count
);

  logic [2:0] w_code;
  logic       w_illegal;
  logic       w_load;

  ula_op_decode u_decode (
    .i_alu_op  (alu_op),
    .i_funct   (funct),
    .o_code    (w_code),
    .o_illegal (w_illegal)
  );

  assign w_load = in_valid & ~stall & ~flush;

  // Pipeline register
  logic       r_valid, w_valid_d;
  logic [2:0] r_code, w_code_d;
  logic       r_ill, w_ill_d;

  always_comb begin
    w_valid_d = r_valid;
    w_code_d  = r_code;
    w_ill_d   = r_ill;
    // Flush, or an empty slot while not stalled, both produce a bubble
    if (flush || (!stall && !in_valid)) begin
      w_valid_d = 1'b0;
      w_code_d  = 3'b000;
      w_ill_d   = 1'b0;
    end else if (w_load) begin
      w_valid_d = 1'b1;
      w_code_d  = w_code;
      w_ill_d   = w_illegal;
    end
  end

  // Counters, packed so the whole bank is one vector
  logic [NumCnt-1:0][31:0] r_cnt, w_cnt_d;
  logic [31:0]             r_ill_cnt, w_ill_cnt_d;
  logic [31:0]             r_rd_data;

  always_comb begin
    w_cnt_d     = r_cnt;
    w_ill_cnt_d = r_ill_cnt;
    if (clr_stats) begin
      w_cnt_d     = '0;
      w_ill_cnt_d = '0;
    end else if (w_load) begin
      // Codes 011/100/101 are never produced by the decoder, so those stay 0
      if (r_cnt[w_code] != '1) w_cnt_d[w_code] = r_cnt[w_code] + 32'd1;
      if (w_illegal && (r_ill_cnt != '1)) w_ill_cnt_d = r_ill_cnt + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid   <= 1'b0;
      r_code    <= 3'b000;
      r_ill     <= 1'b0;
      r_cnt     <= '0;
      r_ill_cnt <= '0;
      r_rd_data <= '0;
    end else begin
      r_valid   <= w_valid_d;
      r_code    <= w_code_d;
      r_ill     <= w_ill_d;
      r_cnt     <= w_cnt_d;
      r_ill_cnt <= w_ill_cnt_d;
      // Reads the current bank, so a same-cycle increment is not visible
      r_rd_data <= r_cnt[rd_idx];
    end
  end

  assign out_valid     = r_valid;
  assign ula_ctrl      = r_code;
  assign illegal       = r_ill;
  assign rd_data       = r_rd_data;
  assign illegal_count = r_ill_cnt;

endmodule

// File: tb/tb_ula_ctrl_stage.sv
module tb_ula_ctrl_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [1:0]  alu_op = 2'b00;
  logic [5:0]  funct = 6'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        clr_stats = 1'b0;
  logic [2:0]  rd_idx = 3'b0;
  logic        out_valid;
  logic [2:0]  ula_ctrl;
  logic        illegal;
  logic [31:0] rd_data;
  logic [31:0] illegal_count;

  ula_ctrl_stage dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .alu_op        (alu_op),
    .funct         (funct),
    .stall         (stall),
    .flush         (flush),
    .clr_stats     (clr_stats),
    .rd_idx        (rd_idx),
    .out_valid     (out_valid),
    .ula_ctrl      (ula_ctrl),
    .illegal       (illegal),
    .rd_data       (rd_data),
    .illegal_count (illegal_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ov;
    logic [2:0]  code;
    logic        ill;
    logic [31:0] rd;
    logic [31:0] icnt;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;

  // Reference state
  logic [31:0] m_cnt [8];
  logic [31:0] m_icnt;
  logic        m_ov;
  logic [2:0]  m_code;
  logic        m_ill;
  bit          rel_pending = 0;

  localparam logic [31:0] Max = 32'hFFFF_FFFF;

  // Recognised funct values and their codes, as a lookup table
  logic [5:0] fn_tab [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  logic [2:0] cd_tab [5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};

  task automatic ref_decode(input logic [1:0] op, input logic [5:0] fn,
                            output logic [2:0] code, output logic ill);
    ill = 1'b0;
    if (op == 2'b00) code = 3'b010;
    else if (op == 2'b01) code = 3'b110;
    else if (op == 2'b11) code = 3'b001;
    else begin
      code = 3'b010;
      ill  = 1'b1;
      for (int i = 0; i < 5; i++) begin
        if (fn_tab[i] == fn) begin
          code = cd_tab[i];
          ill  = 1'b0;
        end
      end
    end
  endtask

  task automatic model_step(input logic rst, input logic iv, input logic [1:0] op,
                            input logic [5:0] fn, input logic st, input logic fl,
                            input logic clr, input logic [2:0] ri);
    exp_t       e;
    logic [2:0] code;
    logic       ill;
    bit         load;
    if (rst) begin
      m_ov = 0; m_code = 0; m_ill = 0; m_icnt = 0;
      for (int i = 0; i < 8; i++) m_cnt[i] = 0;
      e.rd = 0;
    end else begin
      e.rd = m_cnt[ri];
      ref_decode(op, fn, code, ill);
      load = iv && !st && !fl;
      if (fl || (!st && !iv)) begin
        m_ov = 0; m_code = 0; m_ill = 0;
      end else if (load) begin
        m_ov = 1; m_code = code; m_ill = ill;
      end
      if (clr) begin
        m_icnt = 0;
        for (int i = 0; i < 8; i++) m_cnt[i] = 0;
      end else if (load) begin
        if (m_cnt[code] != Max) m_cnt[code] = m_cnt[code] + 1;
        if (ill && m_icnt != Max) m_icnt = m_icnt + 1;
      end
    end
    e.ov = m_ov; e.code = m_code; e.ill = m_ill; e.icnt = m_icnt;
    q.push_back(e);
  endtask

  task automatic drive(input logic rst, input logic iv, input logic [1:0] op,
                       input logic [5:0] fn, input logic st, input logic fl,
                       input logic clr, input logic [2:0] ri);
    @(negedge clk);
    if (rel_pending) begin
      release dut.r_cnt;
      rel_pending = 0;
    end
    reset = rst; in_valid = iv; alu_op = op; funct = fn;
    stall = st; flush = fl; clr_stats = clr; rd_idx = ri;
    model_step(rst, iv, op, fn, st, fl, clr, ri);
  endtask

  // Preload counter[0] with all-ones, then idle one cycle reading it
  task automatic force_cnt0();
    logic [255:0] v;
    @(negedge clk);
    m_cnt[0] = Max;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = m_cnt[i];
    force dut.r_cnt = v;
    rel_pending = 1;
    reset = 0; in_valid = 0; alu_op = 0; funct = 0;
    stall = 0; flush = 0; clr_stats = 0; rd_idx = 0;
    model_step(0, 0, 2'b00, 6'd0, 0, 0, 0, 3'd0);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every edge the DUT presents a registered result
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("out_valid", {31'd0, out_valid}, {31'd0, e.ov});
      chk("ula_ctrl", {29'd0, ula_ctrl}, {29'd0, e.code});
      chk("illegal", {31'd0, illegal}, {31'd0, e.ill});
      chk("rd_data", rd_data, e.rd);
      chk("illegal_count", illegal_count, e.icnt);
    end
  end

  initial begin
    logic [1:0] op;
    logic [5:0] fn;
    // Reset
    drive(1, 0, 2'b00, 6'd0, 0, 0, 0, 3'd0);
    drive(1, 1, 2'b10, 6'b100000, 0, 0, 0, 3'd2);
    // SUB via funct, then read counter[6]
    drive(0, 1, 2'b10, 6'b100010, 0, 0, 0, 3'd6);
    drive(0, 0, 2'b00, 6'd0, 0, 0, 0, 3'd6);
    drive(0, 0, 2'b00, 6'd0, 0, 0, 0, 3'd6);
    // Illegal funct, then read counter[2]
    drive(0, 1, 2'b10, 6'b000111, 0, 0, 0, 3'd2);
    drive(0, 0, 2'b00, 6'd0, 0, 0, 0, 3'd2);
    drive(0, 0, 2'b00, 6'd0, 0, 0, 0, 3'd2);
    // Valid op with stall and flush together
    drive(0, 1, 2'b01, 6'd0, 0, 0, 0, 3'd6);
    drive(0, 1, 2'b00, 6'd0, 1, 1, 0, 3'd2);
    drive(0, 1, 2'b11, 6'd0, 1, 0, 0, 3'd1);
    drive(0, 0, 2'b00, 6'd0, 0, 0, 0, 3'd1);
    // Saturation of counter[0]
    force_cnt0();
    drive(0, 1, 2'b10, 6'b100100, 0, 0, 0, 3'd0);
    drive(0, 0, 2'b00, 6'd0, 0, 0, 0, 3'd0);
    drive(0, 0, 2'b00, 6'd0, 0, 0, 0, 3'd0);
    // Read-during-increment: counter[2]=5, then another ADD load
    drive(0, 0, 2'b00, 6'd0, 0, 0, 1, 3'd0);
    for (int i = 0; i < 5; i++) drive(0, 1, 2'b00, 6'd0, 0, 0, 0, 3'd2);
    drive(0, 1, 2'b00, 6'd0, 0, 0, 0, 3'd2);
    drive(0, 0, 2'b00, 6'd0, 0, 0, 0, 3'd2);
    // Clear competing with a load
    drive(0, 1, 2'b10, 6'b111111, 0, 0, 1, 3'd2);
    drive(0, 0, 2'b00, 6'd0, 0, 0, 0, 3'd2);
    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      op = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) < 7) fn = fn_tab[$urandom_range(0, 4)];
      else fn = 6'($urandom);
      drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 8), op, fn,
            ($urandom_range(0, 9) < 2), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 99) < 2), 3'($urandom));
    end
    // Reset during a load with clr_stats, then read everything back
    drive(0, 1, 2'b10, 6'b101010, 0, 0, 0, 3'd7);
    drive(1, 1, 2'b10, 6'b101010, 0, 0, 1, 3'd7);
    for (int i = 0; i < 8; i++) drive(0, 0, 2'b00, 6'd0, 0, 0, 0, 3'(i));
    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ula_ctrl_stage.md
ULA_CTRL_STAGE -- requirements
Module: ula_ctrl_stage

Interface
REQ-001 SHALL have a single clock and a synchronous, active-high reset.
REQ-002 Ports, one per line, as name, direction, width, meaning:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous reset, active-high
- in_valid  in  1  decode slot carries an instruction
- alu_op  in  2  main-control ALUOp
- funct  in  6  instruction funct field
- stall  in  1  hold the stage
- flush  in  1  insert a bubble
- clr_stats  in  1  clear all counters
- rd_idx  in  3  counter select for readout
- out_valid  out  1  ula_ctrl is valid
- ula_ctrl  out  3  ALU operation code (ULAcontrol)
- illegal  out  1  registered op was undecodable
- rd_data  out  32  selected op counter
- illegal_count  out  32  illegal-decode counter
REQ-003 SHALL have no parameters; all widths are fixed.

Function
REQ-004 Decode SHALL map alu_op 00 to ADD 010, alu_op 01 to SUB 110, and alu_op 11 to OR 001.
REQ-005 For alu_op 10, funct SHALL map as: 100000 to 010, 100010 to 110, 100100 to 000, 100101 to 001, 101010 to 111.
REQ-006 Any other funct with alu_op 10 SHALL decode to 010 with the illegal flag set.
REQ-007 "Load" SHALL mean in_valid=1, stall=0 and flush=0.
REQ-008 On load, out_valid, ula_ctrl and illegal SHALL register the decode, giving 1-cycle latency.
REQ-009 Priority SHALL be reset > flush > stall > load.
REQ-010 Flush SHALL set out_valid=0, ula_ctrl=000 and illegal=0 next cycle, even when stall is also 1.
REQ-011 Stall without flush SHALL hold out_valid, ula_ctrl and illegal unchanged.
REQ-012 in_valid=0 with no stall and no flush SHALL produce a bubble, identical to flush.
REQ-013 Eight 32-bit op counters, indexed by the 3-bit code, SHALL each increment on a load of that code.
REQ-014 The counters for 011, 100 and 101 SHALL exist but never increment.
REQ-015 illegal_count SHALL increment on a load with the illegal decode.
REQ-016 An illegal load SHALL also increment counter[2], because it decodes to 010.
REQ-017 All counters SHALL saturate at FFFFFFFF with no wrap-around.
REQ-018 clr_stats SHALL zero all counters next cycle, and SHALL win over a simultaneous increment.
REQ-019 rd_data SHALL equal counter[rd_idx] as sampled at the previous edge, giving 1-cycle latency.
REQ-020 A read and an increment of the same index in one cycle SHALL return the pre-increment value.
REQ-021 Stall and flush SHALL never change any counter.

Reset
REQ-022 Reset SHALL force out_valid=0, ula_ctrl=000, illegal=0, every counter=0, illegal_count=0 and rd_data=0.
REQ-023 Reset asserted mid-operation SHALL override load, stall, flush and clr_stats in that cycle.
REQ-024 The first load SHALL be accepted on the first edge after reset deasserts.

Structure
REQ-025 Shared package ula_pkg SHALL hold:
- the ULAcontrol code enum: AND, OR, ADD, SUB, SLT
- the ALUOp enum
- the funct constants
REQ-026 Sub-module ula_op_decode SHALL be purely combinational, mapping alu_op and funct to code and illegal.
REQ-027 ula_ctrl_stage SHALL contain the pipeline register, the counters and the read port.
REQ-028 Implementation SHALL be 120-400 lines of RTL with no latches.

Verification
REQ-029 The bench SHALL cover these directed scenarios:
- Load alu_op=10, funct=100010 -> next cycle out_valid=1, ula_ctrl=110, illegal=0; counter[6]=1.
- Load alu_op=10, funct=000111 -> ula_ctrl=010, illegal=1; illegal_count=1 and counter[2]=1.
- Valid op with stall=1 and flush=1 -> out_valid=0, ula_ctrl=000; no counter changes.
- Force counter[0] to FFFFFFFF, then load AND -> counter[0] stays FFFFFFFF.
- rd_idx=2 while an ADD loads with counter[2]=5 -> rd_data=5, then 6 one cycle later.
- Reset asserted during a load with clr_stats=1 -> all outputs and counters read 0 next cycle.
